chord_voice_allocator: RTL and testbench
========================================

# chord_voice_allocator

Schedules note events from the song reader onto a fixed pool of note-player voices so that up to NUM_VOICES notes sound at once. It sits between the song reader and the per-voice note players inside the chord player. It assigns each incoming note to a free voice and counts down each voice's duration on the 48 Hz beat. When every voice has expired it reports note completion back to the song reader.

## Interface
- NUM_VOICES, 3: number of voice slots (2..8)
- NOTE_W, 6: note code width; code 0 is a rest
- DUR_W, 6: duration width, in beats

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- play  in  1  high = beat countdown enabled; low = all countdowns frozen
- beat  in  1  one-cycle pulse, 48 Hz
- new_note  in  1  one-cycle pulse; note and duration are valid
- note  in  NOTE_W  note code to allocate
- duration  in  DUR_W  note length in beats
- voice_load  out  NUM_VOICES  one-hot, one-cycle pulse: the note player loads voice_note
- voice_note  out  NUM_VOICES*NOTE_W  per-voice note code; slot i is in bits [i*NOTE_W +: NOTE_W]
- voice_active  out  NUM_VOICES  voice i has remaining beats > 0
- note_done  out  1  level; high when play=1 and voice_active==0
- overflow  out  1  one-cycle pulse: a note was stolen or dropped because the pool was full

## Operation
- Per-voice state: note register (NOTE_W bits) and remaining-beat counter (DUR_W bits). A voice is free when remaining==0.
- new_note with note==0 (rest) or duration==0: ignored. No load, no overflow.
- new_note with a valid note:
  - Target is the lowest-index free voice.
  - Voice state is written: note, remaining=duration.
  - voice_load[target] pulses.
- Pool full: handled per the Configuration section.
- Beat with play=1: every active voice decrements remaining by 1. It saturates at 0 and never wraps.
- Beat with play=0: no change to any counter.
- new_note is accepted whether or not play is high.
- voice_note holds the last loaded code after its voice expires. Downstream players gate their output on voice_active.

## Timing
- Reset (async assert):
  - All counters and note registers go to 0.
  - voice_load=0, voice_active=0, overflow=0, note_done=0.
- new_note in cycle N:
  - Voice registers update at the edge ending cycle N.
  - voice_load and overflow are registered pulses in cycle N+1.
  - voice_active and voice_note reflect the new note in cycle N+1.
- Free/steal selection uses state from the start of cycle N.
  - A voice that expires on a beat in cycle N is not free for a new_note in cycle N.
  - If beat and new_note land in the same cycle, the newly loaded voice is not decremented. Other voices are.
- note_done is combinational from play and voice_active. It rises the cycle after the last voice reaches 0.
- Back-to-back new_note on consecutive cycles must be supported with no lost events.
- Reset asserted mid-note: all voices clear immediately. No voice_load pulse follows reset release.

## Configuration
- VOICE_STEAL_EN defined: when the pool is full, the new note steals the voice with the smallest remaining count (ties go to the lowest index). That voice reloads, voice_load pulses on it, and overflow pulses.
- VOICE_STEAL_EN undefined: when the pool is full, the new note is dropped, overflow pulses, and voice_load stays 0.

## Structure
- Shared package music_pkg holds:
  - NOTE_W and DUR_W defaults
  - REST_NOTE = 0
  - the voice_state_t struct {note, remaining}
- Sub-module voice_slot: one per voice. It holds the note and counter, decrements on the enable input, loads on the load input, and outputs active.
- The top level contains:
  - the priority encoder for the free voice
  - the min-remaining comparator tree, present only under VOICE_STEAL_EN
  - the output register stage

## Test plan
- Reset, then new_note with note=12, dur=3 → voice_load=001 one cycle later and voice_active=001. After 3 beats with play=1: voice_active=000 and note_done=1.
- Three notes (dur 4, 2, 6) on consecutive cycles → voice_load sequence 001, 010, 100 on consecutive cycles. After 2 beats, voice_active=101.
- Fourth note with the pool full, remaining=(3,1,5):
  - With VOICE_STEAL_EN: voice_load=010 and overflow=1.
  - Without it: voice_load=000 and overflow=1.
- play=0 with 5 beats pulsed → counters unchanged. Then play=1 → countdown resumes from the held values.
- A rest (note=0) or dur=0 → no voice_load and no overflow. A beat coincident with a new_note on the only free voice → that voice keeps its full duration.
- Async reset asserted with 2 voices active → voice_active=0 immediately, with no clock edge. After release, no stray voice_load pulse.

Source files
------------

// File: rtl/music_pkg.sv
// Shared music-path definitions: default field widths, rest code and the
// per-voice state record used by the chord player.
package music_pkg;

  localparam int DEF_NOTE_W = 6;
  localparam int DEF_DUR_W  = 6;

  localparam logic [DEF_NOTE_W-1:0] REST_NOTE = '0;

  typedef struct packed {
    logic [DEF_NOTE_W-1:0] note;
    logic [DEF_DUR_W-1:0]  remaining;
  } voice_state_t;

endpackage

// File: rtl/voice_slot.sv
// One voice of the chord allocator: holds a note code and its remaining-beat
// counter; a load always wins over a decrement in the same cycle.
module voice_slot
  import music_pkg::*;
#(
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int DUR_W  = DEF_DUR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              dec,
  input  logic [NOTE_W-1:0] load_note,
  input  logic [DUR_W-1:0]  load_dur,
  output logic [NOTE_W-1:0] note,
  output logic [DUR_W-1:0]  remaining,
  output logic              active
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      note      <= '0;
      remaining <= '0;
    end else if (load) begin
      note      <= load_note;
      remaining <= load_dur;
    end else if (dec && remaining != '0) begin
      remaining <= remaining - DUR_W'(1);
    end
  end

  assign active = (remaining != '0);

endmodule

// File: rtl/chord_voice_allocator.sv
// Allocates incoming notes onto a pool of voice_slot instances and counts
// them down on the beat. Optional feature macro: VOICE_STEAL_EN.
module chord_voice_allocator
  import music_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int DUR_W      = DEF_DUR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play,
  input  logic                         beat,
  input  logic                         new_note,
  input  logic [NOTE_W-1:0]            note,
  input  logic [DUR_W-1:0]             duration,
  output logic [NUM_VOICES-1:0]        voice_load,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic                         note_done,
  output logic                         overflow
);

  logic                             valid;
  logic                             any_free;
  logic                             dec;
  logic [NUM_VOICES-1:0]            free_sel;
  logic [NUM_VOICES-1:0]            load_sel;
  logic [NUM_VOICES-1:0][DUR_W-1:0] remaining;

  assign valid    = new_note && (note != NOTE_W'(REST_NOTE)) && (duration != '0);
  assign any_free = ~&voice_active;
  assign dec      = play & beat;

  // Lowest-index free voice, from state at the start of the cycle
  always_comb begin
    free_sel = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!voice_active[i] && free_sel == '0) free_sel[i] = 1'b1;
    end
  end

`ifdef VOICE_STEAL_EN
  localparam int IDX_W = $clog2(NUM_VOICES);

  logic [NUM_VOICES-1:0] steal_sel;
  logic [DUR_W-1:0]      min_rem;
  logic [IDX_W-1:0]      min_idx;

  // Strict less-than keeps the lowest index on ties
  always_comb begin
    min_rem   = remaining[0];
    min_idx   = '0;
    steal_sel = '0;
    for (int unsigned i = 1; i < NUM_VOICES; i++) begin
      if (remaining[i] < min_rem) begin
        min_rem = remaining[i];
        min_idx = IDX_W'(i);
      end
    end
    steal_sel[min_idx] = 1'b1;
  end

  assign load_sel = !valid   ? '0 :
                    any_free ? free_sel : steal_sel;
`else
  logic unused_remaining;

  assign load_sel         = (valid && any_free) ? free_sel : '0;
  assign unused_remaining = ^remaining;
`endif

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    voice_slot #(
      .NOTE_W (NOTE_W),
      .DUR_W  (DUR_W)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load_sel[g]),
      .dec       (dec),
      .load_note (note),
      .load_dur  (duration),
      .note      (voice_note[g*NOTE_W +: NOTE_W]),
      .remaining (remaining[g]),
      .active    (voice_active[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      voice_load <= '0;
      overflow   <= 1'b0;
    end else begin
      voice_load <= load_sel;
      overflow   <= valid & ~any_free;
    end
  end

  // Held low during reset even if play is already high
  assign note_done = play & ~reset & ~|voice_active;

endmodule

// File: tb/tb_chord_voice_allocator.sv
// Scoreboard bench for chord_voice_allocator; expectations follow the build's
// VOICE_STEAL_EN setting.
module tb_chord_voice_allocator;
  import music_pkg::*;

  localparam int NV = 3;

  logic          clk;
  logic          reset;
  logic          play;
  logic          beat;
  logic          new_note;
  logic [5:0]    note;
  logic [5:0]    duration;
  logic [NV-1:0] voice_load;
  logic [NV*6-1:0] voice_note;
  logic [NV-1:0] voice_active;
  logic          note_done;
  logic          overflow;

  int checks;
  int fails;

  voice_state_t mdl[NV];
  logic [3:0]   exp_q[$];
  logic [3:0]   ex;

  chord_voice_allocator #(
    .NUM_VOICES (NV),
    .NOTE_W     (6),
    .DUR_W      (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .beat         (beat),
    .new_note     (new_note),
    .note         (note),
    .duration     (duration),
    .voice_load   (voice_load),
    .voice_note   (voice_note),
    .voice_active (voice_active),
    .note_done    (note_done),
    .overflow     (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [NV-1:0] mdl_active();
    logic [NV-1:0] a;
    for (int i = 0; i < NV; i++) a[i] = (mdl[i].remaining != 0);
    return a;
  endfunction

  // Drive one cycle of stimulus, push the expected {overflow, voice_load}
  task automatic step(input logic nn, input logic [5:0] n, input logic [5:0] d, input logic b);
    logic [NV-1:0] ld;
    logic          ov;
    logic          fnd;
    new_note = nn; note = n; duration = d; beat = b;
    ld = '0; ov = 1'b0; fnd = 1'b0;
    if (nn && n != 0 && d != 0) begin
      for (int i = 0; i < NV; i++)
        if (!fnd && mdl[i].remaining == 0) begin ld[i] = 1'b1; fnd = 1'b1; end
      if (!fnd) begin
        ov = 1'b1;
`ifdef VOICE_STEAL_EN
        begin
          int mi;
          mi = 0;
          for (int i = 1; i < NV; i++) if (mdl[i].remaining < mdl[mi].remaining) mi = i;
          ld[mi] = 1'b1;
        end
`endif
      end
    end
    exp_q.push_back({ov, ld});
    for (int i = 0; i < NV; i++) begin
      if (ld[i]) begin
        mdl[i].note = n;
        mdl[i].remaining = d;
      end else if (play && b && mdl[i].remaining != 0) begin
        mdl[i].remaining = mdl[i].remaining - 6'd1;
      end
    end
    @(posedge clk);
    #1;
    new_note = 1'b0; note = '0; duration = '0; beat = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    new_note = 1'b0; note = '0; duration = '0; beat = 1'b0;
    for (int i = 0; i < NV; i++) mdl[i] = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; play = 1'b1;
    new_note = 1'b0; note = '0; duration = '0; beat = 1'b0;
    #2;
    checks++;
    if ({voice_load, voice_active, overflow, note_done} !== 8'b0) begin
      fails++;
      $display("FAIL reset_outputs: load=%b active=%b ovf=%b done=%b required all 0",
               voice_load, voice_active, overflow, note_done);
    end
    @(posedge clk); #1;
    checks++;
    if (voice_note !== '0) begin
      fails++; $display("FAIL reset_notes: voice_note=%h required 0", voice_note);
    end
    reset = 1'b0;
    for (int i = 0; i < NV; i++) mdl[i] = '0;
    #1;
    checks++;
    if (note_done !== 1'b1) begin
      fails++; $display("FAIL reset_done_after: note_done=%b required 1", note_done);
    end
  endtask

  task automatic test_single_note();
    do_reset(); play = 1'b1;
    step(1'b1, 6'd12, 6'd3, 1'b0);
    ex = exp_q.pop_front();
    checks++;
    if ({overflow, voice_load} !== ex || ex !== 4'b0001) begin
      fails++; $display("FAIL single_load: got %b required %b", {overflow, voice_load}, 4'b0001);
    end
    checks++;
    if (voice_active !== 3'b001 || voice_note[5:0] !== 6'd12) begin
      fails++; $display("FAIL single_state: active=%b note0=%0d required 001/12", voice_active, voice_note[5:0]);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 6'd0, 6'd0, 1'b1);
      ex = exp_q.pop_front();
      checks++;
      if ({overflow, voice_load} !== ex) begin
        fails++; $display("FAIL single_beat_pulse%0d: got %b required %b", k, {overflow, voice_load}, ex);
      end
      checks++;
      if (voice_active !== (k == 2 ? 3'b000 : 3'b001) || note_done !== (k == 2)) begin
        fails++; $display("FAIL single_countdown%0d: active=%b done=%b", k, voice_active, note_done);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] durs [3];
    durs = '{6'd4, 6'd2, 6'd6};
    do_reset(); play = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 6'(20 + k), durs[k], 1'b0);
      ex = exp_q.pop_front();
      checks++;
      if ({overflow, voice_load} !== ex || voice_load !== 3'(1 << k)) begin
        fails++; $display("FAIL b2b_load%0d: got %b required %b", k, {overflow, voice_load}, ex);
      end
    end
    checks++;
    if (voice_note !== {6'd22, 6'd21, 6'd20}) begin
      fails++; $display("FAIL b2b_notes: voice_note=%h required %h", voice_note, {6'd22, 6'd21, 6'd20});
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 6'd0, 6'd0, 1'b1);
      ex = exp_q.pop_front();
      checks++;
      if ({overflow, voice_load} !== ex) begin
        fails++; $display("FAIL b2b_beat%0d: got %b required %b", k, {overflow, voice_load}, ex);
      end
    end
    checks++;
    if (voice_active !== 3'b101) begin
      fails++; $display("FAIL b2b_active: active=%b required 101", voice_active);
    end
  endtask

  task automatic test_pool_full();
    logic [3:0] want;
    do_reset(); play = 1'b1;
    step(1'b1, 6'd20, 6'd4, 1'b0);
    step(1'b1, 6'd21, 6'd2, 1'b0);
    step(1'b1, 6'd22, 6'd6, 1'b0);
    step(1'b0, 6'd0, 6'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      ex = exp_q.pop_front();
    end
    step(1'b1, 6'd33, 6'd2, 1'b0);
    ex = exp_q.pop_front();
`ifdef VOICE_STEAL_EN
    want = 4'b1010;
`else
    want = 4'b1000;
`endif
    checks++;
    if ({overflow, voice_load} !== want || ex !== want) begin
      fails++; $display("FAIL full_pool: got %b required %b", {overflow, voice_load}, want);
    end
    checks++;
    if (voice_note[11:6] !== mdl[1].note || voice_active !== 3'b111) begin
      fails++; $display("FAIL full_pool_state: note1=%0d active=%b required %0d/111",
                        voice_note[11:6], voice_active, mdl[1].note);
    end
  endtask

  task automatic test_play_freeze();
    do_reset(); play = 1'b1;
    step(1'b1, 6'd40, 6'd4, 1'b0);
    ex = exp_q.pop_front();
    play = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 6'd0, 6'd0, 1'b1);
      ex = exp_q.pop_front();
    end
    checks++;
    if (voice_active !== 3'b001 || note_done !== 1'b0) begin
      fails++; $display("FAIL freeze_hold: active=%b done=%b required 001/0", voice_active, note_done);
    end
    play = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 6'd0, 6'd0, 1'b1);
      ex = exp_q.pop_front();
      checks++;
      if (voice_active !== mdl_active() || voice_active !== (k == 3 ? 3'b000 : 3'b001)) begin
        fails++; $display("FAIL freeze_resume%0d: active=%b required %b", k, voice_active, mdl_active());
      end
    end
    play = 1'b0; #1;
    checks++;
    if (note_done !== 1'b0) begin
      fails++; $display("FAIL done_gated_by_play: note_done=%b required 0", note_done);
    end
    play = 1'b1;
  endtask

  task automatic test_rest_and_coincident();
    logic [3:0] want;
    do_reset(); play = 1'b1;
    step(1'b1, 6'd0, 6'd5, 1'b0);
    step(1'b1, 6'd7, 6'd0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      ex = exp_q.pop_front();
      checks++;
      if ({overflow, voice_load} !== ex || ex !== 4'b0000) begin
        fails++; $display("FAIL rest_ignored%0d: got %b required 0000", k, {overflow, voice_load});
      end
    end
    step(1'b1, 6'd10, 6'd5, 1'b0);
    step(1'b1, 6'd11, 6'd5, 1'b0);
    step(1'b1, 6'd12, 6'd3, 1'b1);
    ex = exp_q.pop_front(); ex = exp_q.pop_front(); ex = exp_q.pop_front();
    checks++;
    if ({overflow, voice_load} !== 4'b0100) begin
      fails++; $display("FAIL coincident_load: got %b required 0100", {overflow, voice_load});
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 6'd0, 6'd0, 1'b1);
      ex = exp_q.pop_front();
      checks++;
      if (voice_active !== (k == 2 ? 3'b011 : 3'b111)) begin
        fails++; $display("FAIL coincident_full_dur%0d: active=%b required %b", k, voice_active, mdl_active());
      end
    end
    step(1'b1, 6'd13, 6'd4, 1'b0);
    ex = exp_q.pop_front();
    step(1'b1, 6'd14, 6'd6, 1'b1);
    ex = exp_q.pop_front();
`ifdef VOICE_STEAL_EN
    want = 4'b1001;
`else
    want = 4'b1000;
`endif
    checks++;
    if ({overflow, voice_load} !== want || ex !== want) begin
      fails++; $display("FAIL expiring_not_free: got %b required %b", {overflow, voice_load}, want);
    end
    checks++;
    if (voice_active !== mdl_active()) begin
      fails++; $display("FAIL expiring_state: active=%b required %b", voice_active, mdl_active());
    end
  endtask

  task automatic test_async_reset();
    do_reset(); play = 1'b1;
    step(1'b1, 6'd50, 6'd9, 1'b0);
    step(1'b1, 6'd51, 6'd9, 1'b0);
    ex = exp_q.pop_front(); ex = exp_q.pop_front();
    checks++;
    if (voice_active !== 3'b011) begin
      fails++; $display("FAIL async_setup: active=%b required 011", voice_active);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (voice_active !== 3'b000 || note_done !== 1'b0) begin
      fails++; $display("FAIL async_clear: active=%b done=%b required 000/0", voice_active, note_done);
    end
    for (int i = 0; i < NV; i++) mdl[i] = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 6'd0, 6'd0, 1'b0);
      ex = exp_q.pop_front();
      checks++;
      if ({overflow, voice_load} !== ex || voice_load !== 3'b000) begin
        fails++; $display("FAIL async_no_stray%0d: got %b required %b", k, {overflow, voice_load}, ex);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_single_note();
    test_back_to_back();
    test_pool_full();
    test_play_freeze();
    test_rest_and_coincident();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
